// File: rtl/ldtu_rx_word_aligner_pkg.sv
// Shared LiteDTU lane constants and receive aligner FSM state type.
package ldtu_rx_word_aligner_pkg;

  localparam int NBITS = 32;

  // Lane idle patterns, also used by the transmit mux.
  localparam logic [NBITS-1:0] IDLE_EA = 32'hEAAAAAAA;
  localparam logic [NBITS-1:0] IDLE_5A = 32'h5A5A5A5A;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/ldtu_rx_offset_search.sv
// Parallel idle-pattern search over all 32 bit rotations of {prev, cur}.
// Reports the lowest matching offset so periodic patterns resolve uniquely.
module ldtu_rx_offset_search
  import ldtu_rx_word_aligner_pkg::*;
(
  input  logic [NBITS-1:0] prev,
  input  logic [NBITS-1:0] cur,
  input  logic [NBITS-1:0] pattern,
  output logic             match,
  output logic [4:0]       offset
);

  logic [2*NBITS-1:0] pair;
  assign pair = {prev, cur};

  // Priority encoder: scanning from the top down lets the lowest k win.
  always_comb begin
    match  = 1'b0;
    offset = 5'd0;
    for (int k = NBITS-1; k >= 0; k--) begin
      if (pair[k +: NBITS] == pattern) begin
        match  = 1'b1;
        offset = 5'(k);
      end
    end
  end

endmodule

// File: rtl/ldtu_rx_word_aligner.sv
// LiteDTU receive word aligner: hunts for the lane idle pattern across all
// bit rotations, locks the offset after LOCK_COUNT consecutive matches and
// then forwards re-aligned words with an idle flag.
module ldtu_rx_word_aligner
  import ldtu_rx_word_aligner_pkg::*;
#(
  parameter int LOCK_COUNT = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TEST_ENABLE,
  input  logic             RESYNC,
  input  logic [NBITS-1:0] RAW_WORD,
  input  logic             RAW_VALID,
  output logic [NBITS-1:0] DATA_OUT,
  output logic             DATA_VALID,
  output logic             IDLE_DET,
  output logic             LOCKED,
  output logic [4:0]       BIT_OFFSET
);

  state_t             state;
  logic [NBITS-1:0]   prev;
  logic [7:0]         cnt;
  logic [NBITS-1:0]   pattern;
  logic               hit;
  logic [4:0]         hit_k;
  logic [2*NBITS-1:0] pair_sh;
  logic [NBITS-1:0]   win;
  logic               win_ok;
  logic [7:0]         cnt_nxt;

  assign pattern = TEST_ENABLE ? IDLE_5A : IDLE_EA;

  // Window at the currently held offset, used by CHECK and the data path.
  assign pair_sh = {prev, RAW_WORD} >> BIT_OFFSET;
  assign win     = pair_sh[NBITS-1:0];
  assign win_ok  = (win == pattern);
  assign cnt_nxt = cnt + 8'd1;

  ldtu_rx_offset_search u_search (
    .prev    (prev),
    .cur     (RAW_WORD),
    .pattern (pattern),
    .match   (hit),
    .offset  (hit_k)
  );

  // Alignment FSM, match counter, history word and registered data outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_HUNT;
      prev       <= '0;
      cnt        <= '0;
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
      IDLE_DET   <= 1'b0;
      LOCKED     <= 1'b0;
      BIT_OFFSET <= '0;
    end else begin
      if (RAW_VALID) prev <= RAW_WORD;

      // Forwarding uses the pre-update state, so the locking word is dropped.
      if (state == ST_LOCKED && RAW_VALID) begin
        DATA_OUT   <= win;
        DATA_VALID <= 1'b1;
        IDLE_DET   <= (win == IDLE_EA) || (win == IDLE_5A);
      end else begin
        DATA_VALID <= 1'b0;
        IDLE_DET   <= 1'b0;
      end

      if (RESYNC) begin
        state  <= ST_HUNT;
        cnt    <= '0;
        LOCKED <= 1'b0;
      end else if (RAW_VALID) begin
        case (state)
          ST_HUNT: begin
            if (hit) begin
              BIT_OFFSET <= hit_k;
              cnt        <= 8'd1;
              if (LOCK_COUNT == 1) begin
                state  <= ST_LOCKED;
                LOCKED <= 1'b1;
              end else begin
                state <= ST_CHECK;
              end
            end
          end
          ST_CHECK: begin
            if (win_ok) begin
              cnt <= cnt_nxt;
              if (cnt_nxt == 8'(LOCK_COUNT)) begin
                state  <= ST_LOCKED;
                LOCKED <= 1'b1;
              end
            end else begin
              // Mismatch: back to hunting; this word is not re-searched.
              state <= ST_HUNT;
              cnt   <= '0;
            end
          end
          default: ;  // locked: offset frozen until RESYNC or RST
        endcase
      end
    end
  end

endmodule
